// File: rtl/pattern_detector_param.sv
// Serial pattern detector with a runtime-loadable pattern, overlapping or non-overlapping
// matching, and a saturating match counter.
module pattern_detector_param #(
  parameter int                       PATTERN_WIDTH = 4,
  parameter logic [PATTERN_WIDTH-1:0] PATTERN_RESET = 4'b1011,
  parameter int                       COUNT_WIDTH   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stream_in,
  input  logic                     in_valid,
  input  logic                     overlap_en,
  input  logic                     pattern_load,
  input  logic [PATTERN_WIDTH-1:0] pattern_in,
  input  logic                     count_clear,
  output logic                     pattern_found,
  output logic [COUNT_WIDTH-1:0]   match_count,
  output logic                     count_sat
);

  localparam int                     FILL_W    = $clog2(PATTERN_WIDTH);
  localparam logic [FILL_W-1:0]      FILL_LAST = FILL_W'(PATTERN_WIDTH - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  typedef enum logic {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [PATTERN_WIDTH-1:0] r_history;
  logic [PATTERN_WIDTH-1:0] w_hist_nxt;
  logic [FILL_W-1:0]        r_fill;
  logic [FILL_W-1:0]        w_fill_nxt;
  logic [FILL_W-1:0]        w_fill_inc;
  logic [PATTERN_WIDTH-1:0] r_pattern;
  logic [PATTERN_WIDTH-1:0] w_window;
  logic                     w_match;
  logic                     r_found;
  logic [COUNT_WIDTH-1:0]   r_count;
  logic [COUNT_WIDTH-1:0]   w_count_nxt;
  logic                     r_sat;
  logic                     w_unused_msb;

  // The candidate window is the newest PATTERN_WIDTH-1 held bits plus the arriving bit,
  // so the stored MSB has already left the window by the time it would be compared.
  assign w_window     = {r_history[PATTERN_WIDTH-2:0], stream_in};
  assign w_fill_inc   = r_fill + FILL_W'(1);
  assign w_unused_msb = r_history[PATTERN_WIDTH-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hist_nxt  = r_history;
    w_fill_nxt  = r_fill;
    w_match     = 1'b0;
    if (pattern_load) begin
      w_state_nxt = S_FILL;
      w_hist_nxt  = '0;
      w_fill_nxt  = '0;
    end else if (in_valid) begin
      case (r_state)
        S_FILL: begin
          w_hist_nxt = w_window;
          w_fill_nxt = w_fill_inc;
          if (w_fill_inc == FILL_LAST) begin
            w_state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          w_match = (w_window == r_pattern);
          // Non-overlapping mode restarts from an empty window after every hit.
          if (w_match && !overlap_en) begin
            w_state_nxt = S_FILL;
            w_hist_nxt  = '0;
            w_fill_nxt  = '0;
          end else begin
            w_hist_nxt = w_window;
          end
        end
        default: begin
          w_state_nxt = S_FILL;
        end
      endcase
    end
  end

  // A simultaneous clear and match leaves exactly the new match counted.
  always_comb begin
    w_count_nxt = r_count;
    if (w_match) begin
      if (count_clear) begin
        w_count_nxt = COUNT_WIDTH'(1);
      end else if (r_count != COUNT_MAX) begin
        w_count_nxt = r_count + COUNT_WIDTH'(1);
      end
    end else if (count_clear) begin
      w_count_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_history <= '0;
      r_fill    <= '0;
      r_pattern <= PATTERN_RESET;
      r_found   <= 1'b0;
      r_count   <= '0;
      r_sat     <= 1'b0;
    end else begin
      r_history <= w_hist_nxt;
      r_fill    <= w_fill_nxt;
      if (pattern_load) begin
        r_pattern <= pattern_in;
      end
      r_found   <= w_match;
      r_count   <= w_count_nxt;
      r_sat     <= (w_count_nxt == COUNT_MAX);
    end
  end

  assign pattern_found = r_found;
  assign match_count   = r_count;
  assign count_sat     = r_sat;

endmodule

// File: tb/tb_pattern_detector_param.sv
// Directed bench for pattern_detector_param: a vector table for single-cycle behaviour
// plus hand-written sequences for asynchronous reset and counter saturation.
module tb_pattern_detector_param;

  logic       clk;
  logic       reset;
  logic       stream_in;
  logic       in_valid;
  logic       overlap_en;
  logic       pattern_load;
  logic [3:0] pattern_in;
  logic       count_clear;

  logic       found_a;
  logic [7:0] count_a;
  logic       sat_a;
  logic       found_b;
  logic [1:0] count_b;
  logic       sat_b;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic       rst;
    logic       ld;
    logic [3:0] pin;
    logic       v;
    logic       b;
    logic       ov;
    logic       clr;
    logic       ef;
    logic [7:0] ec;
  } vec_t;

  vec_t vecs[$];

  pattern_detector_param #(
    .PATTERN_WIDTH(4),
    .PATTERN_RESET(4'b1011),
    .COUNT_WIDTH  (8)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .stream_in    (stream_in),
    .in_valid     (in_valid),
    .overlap_en   (overlap_en),
    .pattern_load (pattern_load),
    .pattern_in   (pattern_in),
    .count_clear  (count_clear),
    .pattern_found(found_a),
    .match_count  (count_a),
    .count_sat    (sat_a)
  );

  // Narrow counter with an all-ones pattern to exercise saturation.
  pattern_detector_param #(
    .PATTERN_WIDTH(4),
    .PATTERN_RESET(4'b1111),
    .COUNT_WIDTH  (2)
  ) u_sat (
    .clk          (clk),
    .reset        (reset),
    .stream_in    (stream_in),
    .in_valid     (in_valid),
    .overlap_en   (overlap_en),
    .pattern_load (pattern_load),
    .pattern_in   (pattern_in),
    .count_clear  (count_clear),
    .pattern_found(found_b),
    .match_count  (count_b),
    .count_sat    (sat_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic rst, input logic ld, input logic [3:0] pin,
                              input logic v, input logic b, input logic ov, input logic clr,
                              input logic ef, input logic [7:0] ec);
    vec_t r;
    r.rst = rst; r.ld = ld; r.pin = pin; r.v = v; r.b = b;
    r.ov = ov; r.clr = clr; r.ef = ef; r.ec = ec;
    vecs.push_back(r);
  endfunction

  function automatic void addb(input logic b, input logic ov, input logic clr,
                               input logic ef, input logic [7:0] ec);
    add(1'b0, 1'b0, 4'b0000, 1'b1, b, ov, clr, ef, ec);
  endfunction

  function automatic void addrst();
    add(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic drive(input logic rst, input logic ld, input logic [3:0] pin, input logic v,
                       input logic b, input logic ov, input logic clr);
    @(negedge clk);
    reset        = rst;
    pattern_load = ld;
    pattern_in   = pin;
    in_valid     = v;
    stream_in    = b;
    overlap_en   = ov;
    count_clear  = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_found_b [7];
    logic [1:0] exp_count_b [7];
    logic exp_sat_b [7];

    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1; stream_in = 1'b0; in_valid = 1'b0; overlap_en = 1'b1;
    pattern_load = 1'b0; pattern_in = 4'b0000; count_clear = 1'b0;

    // Reset state
    addrst();
    // Overlapping: 1,0,1,1,0,1,1 hits after bits 4 and 7
    addb(1,1,0,0,0); addb(0,1,0,0,0); addb(1,1,0,0,0); addb(1,1,0,1,1);
    addb(0,1,0,0,1); addb(1,1,0,0,1); addb(1,1,0,1,2);
    // Idle cycle drops the pulse; count_clear alone zeroes the count
    add(0,0,4'b0000,0,1,1,0,0,8'd2);
    add(0,0,4'b0000,0,0,1,1,0,8'd0);
    // Non-overlapping: same stream, single hit
    addrst();
    addb(1,0,0,0,0); addb(0,0,0,0,0); addb(1,0,0,0,0); addb(1,0,0,1,1);
    addb(0,0,0,0,1); addb(1,0,0,0,1); addb(1,0,0,0,1);
    // Gap of invalid cycles inside the window
    addrst();
    addb(1,1,0,0,0); addb(0,1,0,0,0); addb(1,1,0,0,0);
    add(0,0,4'b0000,0,1,1,0,0,8'd0);
    add(0,0,4'b0000,0,1,1,0,0,8'd0);
    add(0,0,4'b0000,0,1,1,0,0,8'd0);
    addb(1,1,0,1,1);
    // Pattern load discards held bits and wins over a valid bit on the same cycle
    addrst();
    addb(1,1,0,0,0); addb(0,1,0,0,0); addb(1,1,0,0,0);
    add(0,1,4'b0110,1,1,1,0,0,8'd0);
    addb(0,1,0,0,0); addb(1,1,0,0,0); addb(1,1,0,0,0); addb(0,1,0,1,1);
    // Reloading the pattern keeps the count
    add(0,1,4'b1011,0,0,1,0,0,8'd1);
    addb(1,1,0,0,1); addb(0,1,0,0,1); addb(1,1,0,0,1); addb(1,1,0,1,2);
    // overlap_en only matters on the match cycle; clear with a match gives 1
    addrst();
    addb(1,0,0,0,0); addb(0,0,0,0,0); addb(1,0,0,0,0); addb(1,1,0,1,1);
    addb(0,0,0,0,1); addb(1,0,0,0,1); addb(1,1,1,1,1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].ld, vecs[i].pin, vecs[i].v, vecs[i].b, vecs[i].ov, vecs[i].clr);
      chk($sformatf("row%0d_found", i), {31'd0, found_a}, {31'd0, vecs[i].ef});
      chk($sformatf("row%0d_count", i), {24'd0, count_a}, {24'd0, vecs[i].ec});
      chk($sformatf("row%0d_sat", i), {31'd0, sat_a}, 32'd0);
    end

    // Asynchronous reset clears outputs without waiting for a clock edge
    drive(1,0,4'b0000,0,0,1,0);
    drive(0,0,4'b0000,1,1,1,0);
    drive(0,0,4'b0000,1,0,1,0);
    drive(0,0,4'b0000,1,1,1,0);
    drive(0,0,4'b0000,1,1,1,0);
    chk("arst_pre_found", {31'd0, found_a}, 32'd1);
    chk("arst_pre_count", {24'd0, count_a}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("arst_found", {31'd0, found_a}, 32'd0);
    chk("arst_count", {24'd0, count_a}, 32'd0);
    chk("arst_sat_b", {31'd0, sat_b}, 32'd0);

    // Reset mid-window: bits 1,0,1 are discarded, then 1,0,1,1 hits only on bit 4
    drive(0,0,4'b0000,1,1,1,0);
    drive(0,0,4'b0000,1,0,1,0);
    drive(0,0,4'b0000,1,1,1,0);
    drive(1,0,4'b0000,0,0,1,0);
    chk("mid_rst_count", {24'd0, count_a}, 32'd0);
    drive(0,0,4'b0000,1,1,1,0);
    chk("mid_b1_found", {31'd0, found_a}, 32'd0);
    drive(0,0,4'b0000,1,0,1,0);
    chk("mid_b2_found", {31'd0, found_a}, 32'd0);
    drive(0,0,4'b0000,1,1,1,0);
    chk("mid_b3_found", {31'd0, found_a}, 32'd0);
    drive(0,0,4'b0000,1,1,1,0);
    chk("mid_b4_found", {31'd0, found_a}, 32'd1);
    chk("mid_b4_count", {24'd0, count_a}, 32'd1);

    // 2-bit counter saturation on seven ones against pattern 1111
    exp_found_b = '{0, 0, 0, 1, 1, 1, 1};
    exp_count_b = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    exp_sat_b   = '{0, 0, 0, 0, 0, 1, 1};
    drive(1,0,4'b0000,0,0,1,0);
    chk("sat_rst_count", {30'd0, count_b}, 32'd0);
    for (int i = 0; i < 7; i++) begin
      drive(0,0,4'b0000,1,1,1,0);
      chk($sformatf("sat_b%0d_found", i + 1), {31'd0, found_b}, {31'd0, exp_found_b[i]});
      chk($sformatf("sat_b%0d_count", i + 1), {30'd0, count_b}, {30'd0, exp_count_b[i]});
      chk($sformatf("sat_b%0d_sat", i + 1), {31'd0, sat_b}, {31'd0, exp_sat_b[i]});
    end
    drive(0,0,4'b0000,1,1,1,1);
    chk("sat_clr_found", {31'd0, found_b}, 32'd1);
    chk("sat_clr_count", {30'd0, count_b}, 32'd1);
    chk("sat_clr_sat", {31'd0, sat_b}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pattern_detector_param.md
PATTERN_DETECTOR_PARAM -- requirements
Module: pattern_detector_param

Interface
REQ-001 Parameter PATTERN_WIDTH, default 4, number of bits in the detected pattern (legal range 2..32).
REQ-002 Parameter PATTERN_RESET, default 4'b1011 (PATTERN_WIDTH bits), pattern value loaded at reset.
REQ-003 Parameter COUNT_WIDTH, default 8, width of the match counter (legal range 1..32).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 stream_in  input  1  serial data bit, sampled when in_valid=1.
REQ-007 in_valid  input  1  qualifies stream_in for the current cycle.
REQ-008 overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-009 pattern_load  input  1  synchronous strobe: capture pattern_in as the new pattern.
REQ-010 pattern_in  input  PATTERN_WIDTH  new pattern; MSB is the first bit expected on the stream.
REQ-011 count_clear  input  1  synchronous clear of match_count.
REQ-012 pattern_found  output  1  registered one-cycle match pulse.
REQ-013 match_count  output  COUNT_WIDTH  number of matches since reset/clear, saturating.
REQ-014 count_sat  output  1  high while match_count equals all ones.

Function
REQ-015 The block SHALL hold a PATTERN_WIDTH-bit history register, a fill counter (0..PATTERN_WIDTH-1), a pattern register and a two-state FSM: FILL (fewer than PATTERN_WIDTH-1 prior valid bits held) and RUN (at least PATTERN_WIDTH-1 prior valid bits held).
REQ-016 On a valid cycle the history SHALL shift left, with stream_in entering the LSB; the first-received bit of a window aligns with the pattern MSB.
REQ-017 A match SHALL occur on a valid cycle in RUN when {history[PATTERN_WIDTH-2:0], stream_in} equals the pattern register.
REQ-018 pattern_found SHALL be set at the same rising edge that samples the completing bit, and SHALL be high for exactly one cycle per match.
REQ-019 In FILL each valid bit SHALL increment the fill counter; on reaching PATTERN_WIDTH-1 valid bits the FSM SHALL move to RUN; no match is possible in FILL.
REQ-020 With overlap_en=1, after a match the FSM SHALL remain in RUN and the history SHALL continue shifting.
REQ-021 With overlap_en=0, after a match the history and fill counter SHALL clear and the FSM SHALL return to FILL, so the next match needs PATTERN_WIDTH fresh valid bits.
REQ-022 overlap_en SHALL be sampled on the cycle of the match only; changes at other times have no effect on state.
REQ-023 When in_valid=0 the history, fill counter and FSM state SHALL hold, and pattern_found SHALL be 0 for the following cycle.
REQ-024 pattern_load=1 SHALL capture pattern_in, clear the history and fill counter, enter FILL and force pattern_found to 0; stream_in on that cycle SHALL be ignored (load takes priority over in_valid).
REQ-025 match_count SHALL increment by 1 per match and saturate at 2^COUNT_WIDTH-1 (no wrap); count_sat SHALL be registered together with match_count.
REQ-026 count_clear=1 without a match SHALL set match_count to 0; count_clear and a match in the same cycle SHALL set match_count to 1.
REQ-027 match_count SHALL NOT be affected by pattern_load.

Reset
REQ-028 While reset=1, asynchronously: history=0, fill counter=0, FSM=FILL, pattern register=PATTERN_RESET, pattern_found=0, match_count=0, count_sat=0.
REQ-029 Reset asserted mid-stream SHALL discard all partial history; after release detection restarts from FILL.

Verification
REQ-030 Defaults, overlap_en=1, valid bits 1,0,1,1,0,1,1 -> pattern_found pulses after bits 4 and 7; match_count=2.
REQ-031 Same stream, overlap_en=0 -> single pulse after bit 4; match_count=1.
REQ-032 Stream 1,0,1 then in_valid=0 for 3 cycles then 1 -> no pulse during the gap; one pulse after the final bit.
REQ-033 pattern_load with pattern_in=4'b0110 after bits 1,0,1, then stream 0,1,1,0 -> no match from pre-load bits; one pulse after the 4th post-load bit.
REQ-034 COUNT_WIDTH=2, overlap_en=1, stream of 7 ones with pattern 4'b1111 -> match_count 1,2,3,3; count_sat=1 from the third match; count_clear with a simultaneous match -> match_count=1.
REQ-035 Reset asserted for 1 cycle after bits 1,0,1 -> outputs 0 immediately; stream 1,0,1,1 after release -> one pulse after bit 4.
